// File: rtl/mmio_interface.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mmio_interface                                                |
// | Purpose  : MiniSys-1A MMIO peripheral block: LEDs, switches, 8-digit      |
// |            7-segment scan, 4x4 keypad scan, two interval timers, PWM and |
// |            an optional watchdog (built when MMIO_WDG_EN is defined).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mmio_interface #(
  parameter int SCAN_DIV = 100000,
  parameter int KEY_DIV  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [23:0] switches,
  output logic [23:0] led_out,
  output logic [7:0]  seg_out,
  output logic [7:0]  an_out,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        pwm_out,
  output logic        wdg_rst_req,
  output logic [1:0]  timer_int
);
  localparam logic [15:0] A_SEG_DATA = 16'hFC00, A_SEG_EN = 16'hFC04, A_KEY = 16'hFC10;
  localparam logic [15:0] A_T1_CTRL = 16'hFC20, A_T1_LOAD = 16'hFC24, A_T1_COUNT = 16'hFC28;
  localparam logic [15:0] A_T2_CTRL = 16'hFC30, A_T2_LOAD = 16'hFC34, A_T2_COUNT = 16'hFC38;
  localparam logic [15:0] A_PWM_PER = 16'hFC40, A_PWM_DUTY = 16'hFC44, A_PWM_CTRL = 16'hFC48;
  localparam logic [15:0] A_WDG_CTRL = 16'hFC50, A_WDG_LOAD = 16'hFC54, A_WDG_KICK = 16'hFC58;
  localparam logic [15:0] A_LED = 16'hFC60, A_SW = 16'hFC70;
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);
  localparam logic [31:0] KEY_LAST  = 32'(KEY_DIV - 1);

  // Replace only the byte lanes enabled in 'lanes'.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] lanes);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // Hex digit to active-high segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  logic [15:0] a;
  logic        unused_addr_hi;
  assign a              = addr[15:0];
  assign unused_addr_hi = ^addr[31:16];

  logic [31:0] seg_data_q, seg_data_d, scan_cnt_q, scan_cnt_d, key_cnt_q, key_cnt_d;
  logic [7:0]  seg_en_q, seg_en_d;
  logic [23:0] led_q, led_d;
  logic [2:0]  digit_q, digit_d;
  logic [1:0]  row_idx_q, row_idx_d, col_low;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d, key_clean_q, key_clean_d;
  logic [1:0]  t_en_q, t_en_d, t_ar_q, t_ar_d, t_ie_q, t_ie_d, t_pend_q, t_pend_d, t_set, t_clr;
  logic [1:0][31:0] t_load_q, t_load_d, t_count_q, t_count_d;
  logic [31:0] pwm_period_q, pwm_period_d, pwm_duty_q, pwm_duty_d, pwm_cnt_q, pwm_cnt_d;
  logic        pwm_en_q, pwm_en_d;

  logic       wr_seg_data, wr_seg_en, wr_led, wr_pwm_per, wr_pwm_duty, wr_pwm_ctrl;
  logic [1:0] wr_t_ctrl, wr_t_load;
  assign wr_seg_data = we && (a == A_SEG_DATA);
  assign wr_seg_en   = we && (a == A_SEG_EN);
  assign wr_led      = we && (a == A_LED);
  assign wr_pwm_per  = we && (a == A_PWM_PER);
  assign wr_pwm_duty = we && (a == A_PWM_DUTY);
  assign wr_pwm_ctrl = we && (a == A_PWM_CTRL);
  assign wr_t_ctrl   = {we && (a == A_T2_CTRL), we && (a == A_T1_CTRL)};
  assign wr_t_load   = {we && (a == A_T2_LOAD), we && (a == A_T1_LOAD)};

`ifdef MMIO_WDG_EN
  logic        wdg_en_q, wdg_en_d;
  logic [31:0] wdg_load_q, wdg_load_d, wdg_cnt_q, wdg_cnt_d;
  logic [2:0]  wdg_req_q, wdg_req_d;
  logic        wr_wdg_ctrl, wr_wdg_load, wr_wdg_kick;
  assign wr_wdg_ctrl = we && (a == A_WDG_CTRL);
  assign wr_wdg_load = we && (a == A_WDG_LOAD);
  assign wr_wdg_kick = we && (a == A_WDG_KICK);

  // Watchdog next state: a kick reloads before the countdown can expire.
  always_comb begin
    wdg_en_d   = wdg_en_q;
    wdg_load_d = wdg_load_q;
    wdg_cnt_d  = wdg_cnt_q;
    wdg_req_d  = (wdg_req_q != 3'd0) ? wdg_req_q - 3'd1 : 3'd0;
    if (wr_wdg_kick) begin
      wdg_cnt_d = wdg_load_q;
    end else if (wdg_en_q && wdg_cnt_q != 32'd0) begin
      wdg_cnt_d = wdg_cnt_q - 32'd1;
      if (wdg_cnt_q == 32'd1) begin
        wdg_en_d  = 1'b0;
        wdg_req_d = 3'd4;
      end
    end
    if (wr_wdg_ctrl && be[0]) begin
      wdg_en_d = wdata[0];
      if (wdata[0]) wdg_cnt_d = wdg_load_q;
    end
    if (wr_wdg_load) wdg_load_d = lane_merge(wdg_load_q, wdata, be);
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdg_en_q   <= 1'b0;
      wdg_load_q <= 32'hFFFF_FFFF;
      wdg_cnt_q  <= 32'd0;
      wdg_req_q  <= 3'd0;
    end else begin
      wdg_en_q   <= wdg_en_d;
      wdg_load_q <= wdg_load_d;
      wdg_cnt_q  <= wdg_cnt_d;
      wdg_req_q  <= wdg_req_d;
    end
  end

  assign wdg_rst_req = (wdg_req_q != 3'd0);
`else
  assign wdg_rst_req = 1'b0;
`endif

  // Next state for display scan, keypad scan, timers, PWM and plain registers.
  always_comb begin
    seg_data_d = seg_data_q;  seg_en_d = seg_en_q;  led_d = led_q;
    scan_cnt_d = scan_cnt_q + 32'd1;  digit_d = digit_q;
    key_cnt_d = key_cnt_q + 32'd1;  row_idx_d = row_idx_q;
    key_code_d = key_code_q;  key_valid_d = key_valid_q;  key_clean_d = key_clean_q;
    t_en_d = t_en_q;  t_ar_d = t_ar_q;  t_ie_d = t_ie_q;  t_load_d = t_load_q;
    t_count_d = t_count_q;  t_set = 2'b00;  t_clr = 2'b00;
    pwm_period_d = pwm_period_q;  pwm_duty_d = pwm_duty_q;  pwm_en_d = pwm_en_q;
    pwm_cnt_d = 32'd0;
    casez (col)
      4'b???0: col_low = 2'd0;
      4'b??01: col_low = 2'd1;
      4'b?011: col_low = 2'd2;
      default: col_low = 2'd3;
    endcase

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = 32'd0;
      digit_d    = digit_q + 3'd1;
    end

    // Keypad: sample columns in the last cycle of each row slot. A scan that
    // ends with every row clean drops the latched key.
    if (key_cnt_q == KEY_LAST) begin
      key_cnt_d = 32'd0;
      row_idx_d = row_idx_q + 2'd1;
      if (col != 4'hF) begin
        key_valid_d = 1'b1;
        key_code_d  = {row_idx_q, col_low};
      end
      if (row_idx_q == 2'd3) begin
        if (key_clean_q && col == 4'hF) begin
          key_valid_d = 1'b0;
          key_code_d  = 4'd0;
        end
        key_clean_d = 1'b1;
      end else if (col != 4'hF) begin
        key_clean_d = 1'b0;
      end
    end

    for (int n = 0; n < 2; n++) begin
      if (t_en_q[n] && t_count_q[n] != 32'd0) begin
        t_count_d[n] = t_count_q[n] - 32'd1;
        if (t_count_q[n] == 32'd1) begin
          t_set[n] = 1'b1;
          if (t_ar_q[n]) t_count_d[n] = t_load_q[n];
          else           t_en_d[n]    = 1'b0;
        end
      end
      if (wr_t_ctrl[n] && be[0]) begin
        t_en_d[n] = wdata[0];
        t_ar_d[n] = wdata[1];
        t_ie_d[n] = wdata[2];
        t_clr[n]  = wdata[3];
      end
      if (wr_t_load[n]) begin
        t_load_d[n]  = lane_merge(t_load_q[n], wdata, be);
        t_count_d[n] = t_load_d[n];
      end
      t_pend_d[n] = t_set[n] | (t_pend_q[n] & ~t_clr[n]);
    end

    if (pwm_en_q && pwm_period_q != 32'd0 && pwm_cnt_q < pwm_period_q - 32'd1)
      pwm_cnt_d = pwm_cnt_q + 32'd1;

    if (wr_seg_data) seg_data_d   = lane_merge(seg_data_q, wdata, be);
    if (wr_seg_en && be[0]) seg_en_d = wdata[7:0];
    if (wr_led) led_d = lane_merge({8'd0, led_q}, wdata, be) & 32'h00FF_FFFF;
    if (wr_pwm_per)  pwm_period_d = lane_merge(pwm_period_q, wdata, be);
    if (wr_pwm_duty) pwm_duty_d   = lane_merge(pwm_duty_q, wdata, be);
    if (wr_pwm_ctrl && be[0]) pwm_en_d = wdata[0];
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_data_q <= '0;  seg_en_q <= '0;  led_q <= '0;
      scan_cnt_q <= '0;  digit_q <= '0;  key_cnt_q <= '0;  row_idx_q <= '0;
      key_code_q <= '0;  key_valid_q <= 1'b0;  key_clean_q <= 1'b1;
      t_en_q <= '0;  t_ar_q <= '0;  t_ie_q <= '0;  t_pend_q <= '0;
      t_load_q <= '0;  t_count_q <= '0;
      pwm_period_q <= '0;  pwm_duty_q <= '0;  pwm_cnt_q <= '0;  pwm_en_q <= 1'b0;
    end else begin
      seg_data_q <= seg_data_d;  seg_en_q <= seg_en_d;  led_q <= led_d;
      scan_cnt_q <= scan_cnt_d;  digit_q <= digit_d;  key_cnt_q <= key_cnt_d;
      row_idx_q <= row_idx_d;  key_code_q <= key_code_d;
      key_valid_q <= key_valid_d;  key_clean_q <= key_clean_d;
      t_en_q <= t_en_d;  t_ar_q <= t_ar_d;  t_ie_q <= t_ie_d;  t_pend_q <= t_pend_d;
      t_load_q <= t_load_d;  t_count_q <= t_count_d;
      pwm_period_q <= pwm_period_d;  pwm_duty_q <= pwm_duty_d;
      pwm_cnt_q <= pwm_cnt_d;  pwm_en_q <= pwm_en_d;
    end
  end

  // Read mux, purely combinational from addr.
  always_comb begin
    rdata = 32'd0;
    case (a)
      A_SEG_DATA: rdata = seg_data_q;
      A_SEG_EN:   rdata = {24'd0, seg_en_q};
      A_KEY:      rdata = {27'd0, key_valid_q, key_code_q};
      A_T1_CTRL:  rdata = {t_pend_q[0], 28'd0, t_ie_q[0], t_ar_q[0], t_en_q[0]};
      A_T1_LOAD:  rdata = t_load_q[0];
      A_T1_COUNT: rdata = t_count_q[0];
      A_T2_CTRL:  rdata = {t_pend_q[1], 28'd0, t_ie_q[1], t_ar_q[1], t_en_q[1]};
      A_T2_LOAD:  rdata = t_load_q[1];
      A_T2_COUNT: rdata = t_count_q[1];
      A_PWM_PER:  rdata = pwm_period_q;
      A_PWM_DUTY: rdata = pwm_duty_q;
      A_PWM_CTRL: rdata = {31'd0, pwm_en_q};
`ifdef MMIO_WDG_EN
      A_WDG_CTRL: rdata = {31'd0, wdg_en_q};
      A_WDG_LOAD: rdata = wdg_load_q;
`endif
      A_LED:      rdata = {8'd0, led_q};
      A_SW:       rdata = {8'd0, switches};
      default:    rdata = 32'd0;
    endcase
  end

  // Output drive: anodes/segments for the current digit, keypad row, PWM, IRQs.
  always_comb begin
    an_out  = ~(seg_en_q & (8'd1 << digit_q));
    seg_out = 8'hFF;
    if (seg_en_q[digit_q]) seg_out = {1'b1, ~hex_glyph(seg_data_q[{digit_q, 2'b00} +: 4])};
    row       = ~(4'd1 << row_idx_q);
    pwm_out   = pwm_en_q && (pwm_period_q != 32'd0) && (pwm_cnt_q < pwm_duty_q);
    timer_int = t_pend_q & t_ie_q;
    led_out   = led_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_mmio_interface.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mmio_interface                                             |
// | Purpose  : Self-checking bench for mmio_interface with a cycle-count     |
// |            based reference model.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mmio_interface;
  localparam int SCAN_DIV = 2;
  localparam int KEY_DIV  = 3;
  localparam logic [15:0] SEG_DATA = 16'hFC00, SEG_EN = 16'hFC04, KEY = 16'hFC10;
  localparam logic [15:0] T1_CTRL = 16'hFC20, T1_LOAD = 16'hFC24, T1_COUNT = 16'hFC28;
  localparam logic [15:0] T2_CTRL = 16'hFC30, T2_LOAD = 16'hFC34, T2_COUNT = 16'hFC38;
  localparam logic [15:0] PWM_PER = 16'hFC40, PWM_DUTY = 16'hFC44, PWM_CTRL = 16'hFC48;
  localparam logic [15:0] WDG_CTRL = 16'hFC50, WDG_LOAD = 16'hFC54, WDG_KICK = 16'hFC58;
  localparam logic [15:0] LED = 16'hFC60, SW = 16'hFC70;

  logic        clk = 1'b0, rst = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
  logic [23:0] switches = 24'd0, led_out;
  logic [7:0]  seg_out, an_out;
  logic [3:0]  col, row;
  logic        pwm_out, wdg_rst_req;
  logic [1:0]  timer_int;
  logic [15:0] keys_down = 16'd0;
  int          checks = 0, errors = 0;
  int unsigned cyc;
  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  mmio_interface #(.SCAN_DIV(SCAN_DIV), .KEY_DIV(KEY_DIV)) dut (
    .clk(clk), .rst(rst), .we(we), .be(be), .addr(addr), .wdata(wdata), .rdata(rdata),
    .switches(switches), .led_out(led_out), .seg_out(seg_out), .an_out(an_out),
    .col(col), .row(row), .pwm_out(pwm_out), .wdg_rst_req(wdg_rst_req),
    .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  // Edges since reset release; drives the scan, timer and PWM expectations.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Key matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[4*r+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    addr = {16'hFFFF, a}; wdata = d; be = b; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; be = 4'h0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = {16'hFFFF, a};
    #1 d = rdata;
  endtask

  // Timer COUNT after e edges since it was armed with N.
  function automatic logic [31:0] exp_count(input int unsigned n, input int unsigned e, input bit ar);
    if (e < n) return 32'(n - e);
    if (!ar)   return 32'd0;
    return 32'(n - ((e - n) % n));
  endfunction

  logic [31:0] v, m32;
  logic [15:0] rw_addr [7] = '{SEG_DATA, SEG_EN, T1_LOAD, T2_LOAD, PWM_PER, PWM_DUTY, LED};
  logic [31:0] rw_mask [7] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00FFFFFF};
  logic [31:0] shadow  [7] = '{default: 32'd0};
  int unsigned t0, t1, t2, e, n1, n2, p, dty, k;
  bit          ar1, ar2;
  logic [7:0]  an_exp, seg_exp, en8;
  logic [3:0]  cm;

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check_eq("rst_an", {24'd0, an_out}, 32'hFF);
    check_eq("rst_seg", {24'd0, seg_out}, 32'hFF);
    check_eq("rst_row", {28'd0, row}, 32'hE);
    check_eq("rst_outs", {28'd0, pwm_out, wdg_rst_req, timer_int}, 32'd0);
    check_eq("rst_led", {8'd0, led_out}, 32'd0);
    @(negedge clk) rst = 1'b1;
    rd(KEY, v);      check_eq("rst_key", v, 32'd0);
    rd(T1_CTRL, v);  check_eq("rst_t1ctrl", v, 32'd0);
    rd(SEG_DATA, v); check_eq("rst_segdata", v, 32'd0);
    rd(WDG_LOAD, v);
`ifdef MMIO_WDG_EN
    check_eq("rst_wdgload", v, 32'hFFFFFFFF);
`else
    check_eq("rst_wdgload", v, 32'd0);
`endif

    // ---------------- register file ----------------
    wr(LED, 32'h00A5A5A5, 4'b0001);
    rd(LED, v); check_eq("led_lane0", v, 32'h000000A5);
    shadow[6] = 32'hA5;
    switches = 24'h123456;
    rd(SW, v); check_eq("sw_read", v, 32'h00123456);
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 6);
      m32 = $urandom;
      cm = 4'($urandom);
      wr(rw_addr[k], m32, cm);
      for (int b = 0; b < 4; b++) if (cm[b]) shadow[k][8*b +: 8] = m32[8*b +: 8];
      shadow[k] &= rw_mask[k];
      rd(rw_addr[k], v); check_eq("rw_reg", v, shadow[k]);
    end
    check_eq("led_out", {8'd0, led_out}, shadow[6]);
    switches = 24'($urandom);
    rd(SW, v); check_eq("sw_rand", v, {8'd0, switches});
    wr(KEY, 32'hFFFFFFFF, 4'hF);  rd(KEY, v);      check_eq("ro_key", v, 32'd0);
    wr(T1_COUNT, 32'h0, 4'hF);    rd(T1_COUNT, v); check_eq("ro_count", v, shadow[2]);
    wr(16'hFC80, 32'h1234, 4'hF); rd(16'hFC80, v); check_eq("unmapped", v, 32'd0);

    // ---------------- timer: plan sequence ----------------
    wr(T1_LOAD, 32'd5, 4'hF);
    wr(T1_CTRL, 32'h7, 4'hF);
    repeat (4) @(posedge clk); #1;
    check_eq("t1_int_early", {30'd0, timer_int}, 32'd0);
    @(posedge clk); #1;
    check_eq("t1_int_fire", {30'd0, timer_int}, 32'd1);
    rd(T1_COUNT, v); check_eq("t1_reload", v, 32'd5);
    wr(T1_CTRL, 32'hF, 4'hF);
    check_eq("t1_w1c", {30'd0, timer_int}, 32'd0);
    wr(T1_CTRL, 32'h0, 4'hF);

    // LOAD written while already enabled: pending at the Nth edge.
    wr(T1_LOAD, 32'd0, 4'hF);
    wr(T1_CTRL, 32'h5, 4'hF);
    wr(T1_LOAD, 32'd4, 4'hF);
    repeat (3) @(posedge clk); #1;
    check_eq("tload_early", {31'd0, timer_int[0]}, 32'd0);
    @(posedge clk); #1;
    check_eq("tload_fire", {31'd0, timer_int[0]}, 32'd1);
    rd(T1_CTRL, v); check_eq("t1_oneshot_ctrl", v, 32'h80000004);
    wr(T1_CTRL, 32'h8, 4'hF);

    // Set and W1C on the same edge: set wins.
    wr(T1_LOAD, 32'd3, 4'hF);
    wr(T1_CTRL, 32'h5, 4'hF);
    repeat (2) @(posedge clk);
    wr(T1_CTRL, 32'hD, 4'hF);
    check_eq("set_beats_clr", {31'd0, timer_int[0]}, 32'd1);
    wr(T1_CTRL, 32'h8, 4'hF);
    check_eq("clr_after", {31'd0, timer_int[0]}, 32'd0);

    // ---------------- timers: randomized ----------------
    for (int it = 0; it < 4; it++) begin
      n1 = $urandom_range(2, 12); n2 = $urandom_range(2, 12);
      ar1 = 1'($urandom); ar2 = 1'($urandom);
      wr(T1_LOAD, n1, 4'hF);
      wr(T2_LOAD, n2, 4'hF);
      wr(T1_CTRL, 32'(5 | (ar1 << 1)), 4'hF); t1 = cyc;
      wr(T2_CTRL, 32'(5 | (ar2 << 1)), 4'hF); t2 = cyc;
      for (int j = 0; j < 5; j++) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        rd(T1_COUNT, v); check_eq("t1_count", v, exp_count(n1, cyc - t1, ar1));
        check_eq("t_int", {30'd0, timer_int}, {30'd0, (cyc - t2) >= n2, (cyc - t1) >= n1});
        rd(T2_COUNT, v); check_eq("t2_count", v, exp_count(n2, cyc - t2, ar2));
      end
      rd(T2_CTRL, v); e = cyc - t2;
      check_eq("t2_ctrl", v, {e >= n2, 28'd0, 1'b1, ar2, ar2 || (e < n2)});
      wr(T1_CTRL, 32'h0, 4'hF); wr(T2_CTRL, 32'h0, 4'hF);
      wr(T1_CTRL, 32'h8, 4'hF); wr(T2_CTRL, 32'h8, 4'hF);
    end

    // ---------------- PWM ----------------
    for (int it = 0; it < 6; it++) begin
      p   = (it == 0) ? 4 : $urandom_range(0, 8);
      dty = (it == 0) ? 1 : $urandom_range(0, 10);
      wr(PWM_PER, p, 4'hF);
      wr(PWM_DUTY, dty, 4'hF);
      wr(PWM_CTRL, 32'h1, 4'hF); t0 = cyc;
      for (int j = 0; j < 2 * p + 4; j++) begin
        @(negedge clk); e = cyc - t0;
        check_eq("pwm", {31'd0, pwm_out}, {31'd0, (p != 0) && ((e % p) < dty)});
      end
      wr(PWM_CTRL, 32'h0, 4'hF);
      check_eq("pwm_off", {31'd0, pwm_out}, 32'd0);
    end

    // ---------------- 7-segment and row scan ----------------
    for (int it = 0; it < 3; it++) begin
      m32 = (it == 0) ? 32'h0000000F : $urandom;
      en8 = (it == 0) ? 8'h01 : 8'($urandom);
      wr(SEG_DATA, m32, 4'hF);
      wr(SEG_EN, {24'd0, en8}, 4'hF);
      for (int j = 0; j < 8 * SCAN_DIV + 3; j++) begin
        @(negedge clk);
        k = (cyc / SCAN_DIV) % 8;
        an_exp = 8'hFF; seg_exp = 8'hFF;
        if (en8[k]) begin
          an_exp[k] = 1'b0;
          seg_exp = {1'b1, ~glyph[m32[4*k +: 4]]};
        end
        check_eq("an_out", {24'd0, an_out}, {24'd0, an_exp});
        check_eq("seg_out", {24'd0, seg_out}, {24'd0, seg_exp});
        check_eq("row", {28'd0, row}, {28'd0, ~(4'd1 << ((cyc / KEY_DIV) % 4))});
      end
    end

    // ---------------- keypad ----------------
    for (int it = 0; it < 4; it++) begin
      k  = (it == 0) ? 1 : $urandom_range(0, 3);
      cm = (it == 0) ? 4'b0100 : 4'($urandom_range(1, 15));
      keys_down = 16'(cm) << (4 * k);
      repeat (5 * KEY_DIV + 2) @(posedge clk);
      e = 0;
      for (int c = 3; c >= 0; c--) if (cm[c]) e = c;
      rd(KEY, v); check_eq("key_press", v, 32'h10 | (4 * k + e));
      keys_down = 16'd0;
      repeat (8 * KEY_DIV + 2) @(posedge clk);
      rd(KEY, v); check_eq("key_release", v, 32'd0);
    end

    // ---------------- watchdog ----------------
`ifdef MMIO_WDG_EN
    for (int it = 0; it < 3; it++) begin
      n1 = (it == 0) ? 3 : $urandom_range(2, 10);
      wr(WDG_LOAD, n1, 4'hF);
      wr(WDG_CTRL, 32'h1, 4'hF); t0 = cyc;
      for (int j = 0; j < int'(n1) + 7; j++) begin
        @(negedge clk); e = cyc - t0;
        check_eq("wdg_req", {31'd0, wdg_rst_req}, {31'd0, e >= n1 && e < n1 + 4});
      end
      rd(WDG_CTRL, v); check_eq("wdg_autodis", v, 32'd0);
    end
    wr(WDG_LOAD, 32'd3, 4'hF);
    wr(WDG_CTRL, 32'h1, 4'hF);
    for (int j = 0; j < 12; j++) begin
      wr(WDG_KICK, 32'd0, 4'hF);
      @(negedge clk); check_eq("wdg_kicked", {31'd0, wdg_rst_req}, 32'd0);
    end
    wr(WDG_CTRL, 32'h0, 4'hF);
`else
    wr(WDG_LOAD, 32'd3, 4'hF); wr(WDG_CTRL, 32'h1, 4'hF);
    rd(WDG_CTRL, v); check_eq("nowdg_ctrl", v, 32'd0);
    rd(WDG_LOAD, v); check_eq("nowdg_load", v, 32'd0);
    repeat (6) @(posedge clk); #1;
    check_eq("nowdg_req", {31'd0, wdg_rst_req}, 32'd0);
`endif

    // ---------------- reset mid-operation ----------------
    wr(T2_LOAD, 32'd3, 4'hF);
    wr(T2_CTRL, 32'h7, 4'hF);
    wr(PWM_PER, 32'd4, 4'hF); wr(PWM_DUTY, 32'd2, 4'hF); wr(PWM_CTRL, 32'h1, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; addr = {16'hFFFF, T2_COUNT};
    #1;
    check_eq("mrst_count", rdata, 32'd0);
    check_eq("mrst_outs", {29'd0, pwm_out, timer_int}, 32'd0);
    @(negedge clk); rst = 1'b1;
    rd(T2_CTRL, v); check_eq("mrst_ctrl", v, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/mmio_interface.md
# mmio_interface

Memory-mapped peripheral block of the MiniSys-1A SoC. It decodes the CPU data-bus window 0xFFFFxxxx (selected upstream) and provides read/write registers for LEDs, switches, an 8-digit 7-segment display, a 4x4 keypad, two interval timers, a PWM output and a watchdog. Timer interrupts feed the CPU external-interrupt inputs, and the watchdog request feeds the system reset logic.

## Interface
- SCAN_DIV, 100000: clk cycles per 7-segment digit slot.
- KEY_DIV, 100000: clk cycles per keypad row slot.
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- we  input  1  write strobe, already qualified by the MMIO window
- be  input  4  byte-lane write enables; be[n] covers wdata[8n+7:8n]
- addr  input  32  byte address; only addr[15:0] decoded
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr
- switches  input  24  board switches
- led_out  output  24  board LEDs, 1 = lit
- seg_out  output  8  segment drive, active-low: [0]=CA … [6]=CG, [7]=DP
- an_out  output  8  digit anodes, active-low; an_out[i] selects digit i
- col  input  4  keypad columns, active-low, externally pulled up
- row  output  4  keypad rows, active-low, one row driven low at a time
- pwm_out  output  1  PWM output
- wdg_rst_req  output  1  watchdog reset request, active-high
- timer_int  output  2  [0] = Timer1 interrupt, [1] = Timer2 interrupt

## Operation
- Register map, word-aligned, offsets in addr[15:0]:
  - FC00 SEG_DATA: RW, 32 bits.
  - FC04 SEG_EN: RW, [7:0].
  - FC10 KEY: RO, {27'b0, valid, code[3:0]}.
  - FC20/FC30 Tn_CTRL: RW.
  - FC24/FC34 Tn_LOAD: RW.
  - FC28/FC38 Tn_COUNT: RO.
  - FC40 PWM_PERIOD, FC44 PWM_DUTY, FC48 PWM_CTRL[0]=enable.
  - FC50 WDG_CTRL[0]=enable, FC54 WDG_LOAD, FC58 WDG_KICK (write-only).
  - FC60 LED: RW, [23:0].
  - FC70 SW: RO, {8'b0, switches}.
- Unmapped or write-only reads return 0. Unmapped writes are ignored. Unused register bits read 0.
- A write takes effect at the clk edge when we=1. Only lanes with be[n]=1 are updated. Writes to RO registers are ignored.
- 7-segment: digit i shows the hex glyph of SEG_DATA[4i+3:4i] when SEG_EN[i]=1. A disabled digit keeps its anode high. DP is always off (seg_out[7]=1).
- Keypad scan: row is driven low one row at a time, cycling 0→3, changing every KEY_DIV cycles.
  - A low column c sampled in the last cycle of row r's slot latches code=4r+c (lowest c wins) and sets valid.
  - valid clears after a full 4-row scan with col=4'hF on every row.
- Timers:
  - CTRL bits: [0] en, [1] auto-reload, [2] int-enable, [3] W1C pending clear (write-only), [31] pending (RO).
  - A write to LOAD also loads COUNT.
  - While en=1 and COUNT≠0, COUNT decrements by 1 per cycle.
  - On the 1→0 transition, pending is set. With auto-reload, COUNT←LOAD; otherwise en←0.
  - timer_int[n] = pending & int-enable. If a set and a W1C clear hit in the same cycle, the set wins.
- PWM:
  - A 32-bit counter runs 0..PERIOD−1 and wraps, while enabled.
  - pwm_out = enable & (cnt < DUTY).
  - PERIOD=0 forces pwm_out=0. DUTY≥PERIOD gives a constant 1.
- Watchdog:
  - A write setting WDG_CTRL[0] loads the counter from WDG_LOAD. A WDG_KICK write reloads it.
  - The counter decrements while enabled.
  - On the 1→0 transition, wdg_rst_req goes high for exactly 4 cycles and enable clears.

## Timing
- rdata is valid in the same cycle as addr; there is no read side effect.
- Register writes are visible on rdata from the cycle after the write edge.
- LOAD=N written with en=1 already set: pending is set at the Nth edge after the write edge.
- Reset values:
  - led_out 0; SEG_DATA 0; SEG_EN 0, giving an_out=8'hFF and seg_out=8'hFF.
  - row=4'b1110; KEY=0.
  - Timers, PWM and watchdog all 0/disabled.
  - pwm_out 0, timer_int 0, wdg_rst_req 0.
  - WDG_LOAD resets to 0xFFFFFFFF.
- Asserting reset mid-operation clears all counters and pending flags immediately.

## Configuration
- MMIO_WDG_EN defined: the watchdog is implemented as above.
- MMIO_WDG_EN undefined:
  - No watchdog logic is built.
  - wdg_rst_req is tied 0.
  - FC50–FC58 read 0 and ignore writes.

## Test plan
- Write LED=0x00A5A5A5 with be=4'b0001, then read LED → 0x000000A5. Read SW with switches=0x123456 → 0x00123456.
- Timer1: LOAD=5, CTRL=0x7 (enable, auto-reload, int-enable) → timer_int[0] high 5 edges later and COUNT reloads to 5. Write CTRL=0xF → pending clears, timer_int[0]=0.
- PWM: PERIOD=4, DUTY=1, enable → pwm_out repeats the pattern 1,0,0,0.
- SEG_DATA=0x0000000F, SEG_EN=0x01, SCAN_DIV=2 → during digit 0 slot, an_out=8'hFE and seg_out=8'h8E ("F").
- Hold col[2] low while row[1] is driven low → KEY reads 0x16 (valid=1, code 6). Release col → KEY returns to 0 after one full scan.
- WDG_LOAD=3, enable, no kick → wdg_rst_req high for 4 cycles starting 3 edges after enable. Kicking every 2 cycles keeps wdg_rst_req at 0.
